// File: rtl/mm_pkg.sv
// Shared types and helpers for the streaming matrix-multiply sequencer.
package mm_pkg;

    localparam int unsigned MAX_DIM_DEF = 8;
    localparam int unsigned DW_DEF      = 4;

    localparam logic [1:0] EP_A_BAD = 2'b01;
    localparam logic [1:0] EP_B_BAD = 2'b10;

    typedef enum logic [2:0] {
        IDLE, LOAD_A, SWAP, LOAD_B, CHECK, COMP, EMIT, REPORT
    } state_e;

    // Row-major operand-buffer address of element (r, c).
    function automatic int unsigned addr(input int unsigned r, input int unsigned c,
                                         input int unsigned max_dim = MAX_DIM_DEF);
        return r * max_dim + c;
    endfunction

endpackage

// File: rtl/mm_shape_trk.sv
// Shape tracker for one matrix: counts elements/rows, latches the first row
// length and flags ragged or oversize input. Reused for A then B.
module mm_shape_trk #(
    parameter int unsigned MAX_DIM = 8,
    parameter int unsigned DW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          elem_i,
    input  logic          row_done_i,
    output logic [DW-1:0] col_o,
    output logic [DW-1:0] row_o,
    output logic [DW-1:0] rows_o,
    output logic [DW-1:0] cols_o,
    output logic          bad_o,
    output logic          room_o
);

    logic [DW-1:0] col_q, row_q, cols_q;
    logic          bad_q;
    logic [DW-1:0] col_b, row_b, cols_b, len_c;
    logic          bad_b;

    // A clear and the first element of the next matrix may land in the same cycle.
    always_comb begin
        col_b  = clr_i ? '0 : col_q;
        row_b  = clr_i ? '0 : row_q;
        cols_b = clr_i ? '0 : cols_q;
        bad_b  = clr_i ? 1'b0 : bad_q;
        len_c  = col_b + DW'(1);
    end

    assign room_o = (col_b < DW'(MAX_DIM)) && (row_b < DW'(MAX_DIM));
    assign col_o  = col_b;
    assign row_o  = row_b;
    assign rows_o = row_q;
    assign cols_o = cols_q;
    assign bad_o  = bad_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            cols_q <= '0;
            bad_q  <= 1'b0;
        end else begin
            col_q  <= col_b;
            row_q  <= row_b;
            cols_q <= cols_b;
            bad_q  <= bad_b;
            if (elem_i) begin
                if (!room_o) bad_q <= 1'b1;
                if (row_done_i) begin
                    col_q <= '0;
                    if (row_b < DW'(MAX_DIM)) row_q <= row_b + DW'(1);
                    if (row_b == '0) cols_q <= len_c;
                    else if (len_c != cols_b) bad_q <= 1'b1;
                end else if (col_b < DW'(MAX_DIM)) begin
                    col_q <= col_b + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Control FSM for the streaming matrix-multiply datapath.
// Optional MM_SEQ_OREADY_EN adds out_ready back-pressure on EMIT/REPORT.
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int unsigned MAX_DIM = MAX_DIM_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned AW      = $clog2(MAX_DIM * MAX_DIM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          col_end,
    input  logic          row_end,
`ifdef MM_SEQ_OREADY_EN
    input  logic          out_ready,
`endif
    output logic          busy,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          out_valid,
    output logic          change_row,
    output logic          is_legal,
    output logic [1:0]    ep
);

    state_e        state_q;
    logic          busy_q, mac_en_q, mac_clr_q, out_valid_q, change_row_q, is_legal_q;
    logic [1:0]    ep_q;
    logic [AW-1:0] rd_a_q, rd_b_q;
    logic [DW-1:0] i_q, j_q, k_q, rows_a_q, cols_a_q, cols_b_q;

    logic          accept_c, out_ready_c, trk_clr_c, trk_bad, trk_room;
    logic          last_i_c, last_j_c, last_k_c;
    logic [DW-1:0] trk_col, trk_row, trk_rows, trk_cols;

`ifdef MM_SEQ_OREADY_EN
    assign out_ready_c = out_ready;
`else
    assign out_ready_c = 1'b1;
`endif

    assign accept_c  = in_valid && !busy_q;
    assign trk_clr_c = (state_q == IDLE) || (state_q == SWAP);
    assign last_i_c  = (i_q == rows_a_q - DW'(1));
    assign last_j_c  = (j_q == cols_b_q - DW'(1));
    assign last_k_c  = (k_q == cols_a_q - DW'(1));

    mm_shape_trk #(.MAX_DIM(MAX_DIM), .DW(DW)) u_trk (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (trk_clr_c),
        .elem_i     (accept_c),
        .row_done_i (col_end || row_end),
        .col_o      (trk_col),
        .row_o      (trk_row),
        .rows_o     (trk_rows),
        .cols_o     (trk_cols),
        .bad_o      (trk_bad),
        .room_o     (trk_room)
    );

    assign wr_en      = accept_c && trk_room;
    assign wr_sel     = (state_q == LOAD_B);
    assign wr_addr    = AW'(addr(32'(trk_row), 32'(trk_col), MAX_DIM));
    assign busy       = busy_q;
    assign rd_addr_a  = rd_a_q;
    assign rd_addr_b  = rd_b_q;
    assign mac_en     = mac_en_q;
    assign mac_clr    = mac_clr_q;
    assign out_valid  = out_valid_q;
    assign change_row = change_row_q;
    assign is_legal   = is_legal_q;
    assign ep         = ep_q;

    // Outputs are set on the transition into the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            mac_en_q     <= 1'b0;
            mac_clr_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            change_row_q <= 1'b0;
            is_legal_q   <= 1'b0;
            ep_q         <= '0;
            rd_a_q       <= '0;
            rd_b_q       <= '0;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            rows_a_q     <= '0;
            cols_a_q     <= '0;
            cols_b_q     <= '0;
        end else begin
            mac_en_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        ep_q <= '0;
                        if (row_end) begin
                            state_q <= SWAP;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD_A;
                        end
                    end
                end
                LOAD_A: begin
                    if (accept_c && row_end) begin
                        state_q <= SWAP;
                        busy_q  <= 1'b1;
                    end
                end
                SWAP: begin
                    rows_a_q <= trk_rows;
                    cols_a_q <= trk_cols;
                    ep_q     <= trk_bad ? EP_A_BAD : 2'b00;
                    state_q  <= LOAD_B;
                    busy_q   <= 1'b0;
                end
                LOAD_B: begin
                    if (accept_c && row_end) begin
                        state_q <= CHECK;
                        busy_q  <= 1'b1;
                    end
                end
                CHECK: begin
                    cols_b_q <= trk_cols;
                    ep_q     <= ep_q | (trk_bad ? EP_B_BAD : 2'b00);
                    i_q      <= '0;
                    j_q      <= '0;
                    k_q      <= '0;
                    if (!trk_bad && ep_q == 2'b00 && cols_a_q == trk_rows) begin
                        state_q   <= COMP;
                        mac_en_q  <= 1'b1;
                        mac_clr_q <= 1'b1;
                        rd_a_q    <= '0;
                        rd_b_q    <= '0;
                    end else begin
                        state_q      <= REPORT;
                        out_valid_q  <= 1'b1;
                        is_legal_q   <= 1'b0;
                        change_row_q <= 1'b0;
                    end
                end
                COMP: begin
                    if (last_k_c) begin
                        state_q      <= EMIT;
                        out_valid_q  <= 1'b1;
                        is_legal_q   <= 1'b1;
                        change_row_q <= last_j_c;
                    end else begin
                        k_q      <= k_q + DW'(1);
                        mac_en_q <= 1'b1;
                        rd_a_q   <= AW'(addr(32'(i_q), 32'(k_q) + 32'd1, MAX_DIM));
                        rd_b_q   <= AW'(addr(32'(k_q) + 32'd1, 32'(j_q), MAX_DIM));
                    end
                end
                EMIT: begin
                    if (out_ready_c) begin
                        out_valid_q  <= 1'b0;
                        is_legal_q   <= 1'b0;
                        change_row_q <= 1'b0;
                        k_q          <= '0;
                        if (last_j_c && last_i_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= COMP;
                            mac_en_q  <= 1'b1;
                            mac_clr_q <= 1'b1;
                            if (last_j_c) begin
                                i_q    <= i_q + DW'(1);
                                j_q    <= '0;
                                rd_a_q <= AW'(addr(32'(i_q) + 32'd1, 32'd0, MAX_DIM));
                                rd_b_q <= '0;
                            end else begin
                                j_q    <= j_q + DW'(1);
                                rd_a_q <= AW'(addr(32'(i_q), 32'd0, MAX_DIM));
                                rd_b_q <= AW'(addr(32'd0, 32'(j_q) + 32'd1, MAX_DIM));
                            end
                        end
                    end
                end
                REPORT: begin
                    if (out_ready_c) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        out_valid_q  <= 1'b0;
                        is_legal_q   <= 1'b0;
                        change_row_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Self-checking bench for mm_seq_ctrl: matrices are described by row lengths and
// the expected per-cycle control trace is built from those shapes.
module tb_mm_seq_ctrl;

    localparam int AW = 6;
    localparam int MD = 8;

    logic clk = 1'b0;
    logic rst, in_valid, col_end, row_end;
`ifdef MM_SEQ_OREADY_EN
    logic out_ready;
`endif
    logic          busy, wr_en, wr_sel, mac_en, mac_clr, out_valid, change_row, is_legal;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [1:0]    ep;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit busy;
        bit mac_en;
        bit mac_clr;
        bit ov;
        bit cr;
        bit lg;
        int ra;
        int rb;
    } ent_t;

    always #5 clk = ~clk;

    mm_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .col_end    (col_end),
        .row_end    (row_end),
`ifdef MM_SEQ_OREADY_EN
        .out_ready  (out_ready),
`endif
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .out_valid  (out_valid),
        .change_row (change_row),
        .is_legal   (is_legal),
        .ep         (ep)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic ent_t mk(bit b, bit me, bit mc, bit ov, bit cr, bit lg, int ra, int rb);
        ent_t e;
        e.busy = b; e.mac_en = me; e.mac_clr = mc; e.ov = ov; e.cr = cr; e.lg = lg;
        e.ra = ra; e.rb = rb;
        return e;
    endfunction

    // A matrix is bad when oversize in either dimension or when its rows differ in length.
    function automatic bit shape_bad(input int lens[$]);
        if (lens.size() > MD) return 1'b1;
        foreach (lens[r]) if (lens[r] > MD || lens[r] != lens[0]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all_zero(input string name);
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || wr_sel !== 1'b0 || wr_addr !== '0 ||
            rd_addr_a !== '0 || rd_addr_b !== '0 || mac_en !== 1'b0 || mac_clr !== 1'b0 ||
            out_valid !== 1'b0 || change_row !== 1'b0 || is_legal !== 1'b0 || ep !== 2'b00) begin
            errors++;
            $display("FAIL %s: outputs got busy=%b wr_en=%b wr_sel=%b wr_addr=%0d rd_a=%0d rd_b=%0d mac_en=%b mac_clr=%b ov=%b cr=%b lg=%b ep=%b, expected all zero",
                     name, busy, wr_en, wr_sel, wr_addr, rd_addr_a, rd_addr_b, mac_en, mac_clr,
                     out_valid, change_row, is_legal, ep);
        end
    endtask

    task automatic drive_matrix(input string name, input int lens[$], input bit sel);
        int guard;
        bit exp_we;
        for (int r = 0; r < lens.size(); r++) begin
            for (int c = 0; c < lens[r]; c++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    col_end  = 1'($urandom_range(0, 1));
                    row_end  = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                in_valid = 1'b1;
                col_end  = (c == lens[r] - 1);
                row_end  = (c == lens[r] - 1) && (r == lens.size() - 1);
                guard = 0;
                @(negedge clk);
                while (busy === 1'b1 && guard < 8) begin
                    guard++;
                    @(negedge clk);
                end
                exp_we = (r < MD) && (c < MD);
                checks++;
                if (busy !== 1'b0 || wr_en !== exp_we || wr_sel !== sel ||
                    (exp_we && wr_addr !== AW'(r * MD + c))) begin
                    errors++;
                    $display("FAIL %s write m%0d[%0d][%0d]: got busy=%b wr_en=%b wr_sel=%b wr_addr=%0d, expected busy=0 wr_en=%b wr_sel=%b wr_addr=%0d",
                             name, sel, r, c, busy, wr_en, wr_sel, wr_addr, exp_we, sel, r * MD + c);
                end
                @(posedge clk); #1;
                if (!sel && r == 0 && c == 0) begin
                    checks++;
                    if (ep !== 2'b00) begin
                        errors++;
                        $display("FAIL %s ep_clear: got ep=%b, expected 00", name, ep);
                    end
                end
            end
        end
        in_valid = 1'b0;
        col_end  = 1'b0;
        row_end  = 1'b0;
    endtask

    task automatic run_case(input string name, input int la[$], input int lb[$], input int abort_at);
        ent_t exp_q[$];
        ent_t e;
        bit bad_a, bad_b, legal;
        logic [1:0] exp_ep;
        bad_a  = shape_bad(la);
        bad_b  = shape_bad(lb);
        legal  = !bad_a && !bad_b && (la[0] == lb.size());
        exp_ep = {bad_b, bad_a};

        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        if (legal) begin
            for (int i = 0; i < la.size(); i++)
                for (int j = 0; j < lb[0]; j++) begin
                    for (int k = 0; k < la[0]; k++)
                        exp_q.push_back(mk(1, 1, k == 0, 0, 0, 0, i * MD + k, k * MD + j));
                    exp_q.push_back(mk(1, 0, 0, 1, j == lb[0] - 1, 1, 0, 0));
                end
        end else begin
            exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        drive_matrix(name, la, 1'b0);
        drive_matrix(name, lb, 1'b1);

        foreach (exp_q[n]) begin
            e = exp_q[n];
            if (n == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(posedge clk); #1;
                @(negedge clk);
                check_all_zero({name, " mid_reset"});
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            // Element strobes while busy must be ignored.
            in_valid = e.busy ? 1'($urandom_range(0, 1)) : 1'b0;
            col_end  = 1'($urandom_range(0, 1));
            row_end  = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (busy !== e.busy || mac_en !== e.mac_en || mac_clr !== e.mac_clr || out_valid !== e.ov ||
                (e.ov && (change_row !== e.cr || is_legal !== e.lg)) ||
                (e.mac_en && (rd_addr_a !== AW'(e.ra) || rd_addr_b !== AW'(e.rb)))) begin
                errors++;
                $display("FAIL %s trace[%0d]: got busy=%b mac_en=%b mac_clr=%b ov=%b cr=%b lg=%b rd_a=%0d rd_b=%0d, expected busy=%b mac_en=%b mac_clr=%b ov=%b cr=%b lg=%b rd_a=%0d rd_b=%0d",
                         name, n, busy, mac_en, mac_clr, out_valid, change_row, is_legal, rd_addr_a, rd_addr_b,
                         e.busy, e.mac_en, e.mac_clr, e.ov, e.cr, e.lg, e.ra, e.rb);
            end
            if (n == exp_q.size() - 1) begin
                checks++;
                if (ep !== exp_ep) begin
                    errors++;
                    $display("FAIL %s ep: got %b, expected %b", name, ep, exp_ep);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        col_end  = 1'b0;
        row_end  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_legal();
        int la[$]; int lb[$];
        la = '{3, 3};
        lb = '{2, 2, 2};
        run_case("legal_2x3_3x2", la, lb, -1);
    endtask

    task automatic test_ragged_a();
        int la[$]; int lb[$];
        la = '{3, 2};
        lb = '{2, 2, 2};
        run_case("ragged_a", la, lb, -1);
    endtask

    task automatic test_mismatch();
        int la[$]; int lb[$];
        la = '{3, 3};
        lb = '{2, 2};
        run_case("mismatch", la, lb, -1);
    endtask

    task automatic test_one_by_one();
        int la[$]; int lb[$];
        la = '{1};
        lb = '{1};
        run_case("one_by_one", la, lb, -1);
    endtask

    task automatic test_oversize();
        int la[$]; int lb[$];
        la = '{9};
        lb = '{1, 1};
        run_case("oversize_cols_a", la, lb, -1);
        la = '{1};
        lb = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_case("oversize_rows_b", la, lb, -1);
        la = '{8, 8, 8, 8, 8, 8, 8, 8};
        lb = '{2, 2, 2, 2, 2, 2, 2, 2};
        run_case("max_8x8", la, lb, -1);
    endtask

    task automatic test_reset_mid();
        int la[$]; int lb[$];
        la = '{3, 3};
        lb = '{2, 2, 2};
        run_case("abort_case1", la, lb, 3);
        run_case("after_reset_case1", la, lb, -1);
    endtask

    task automatic test_random();
        int la[$]; int lb[$];
        int ra, kk, cb, rb, mode;
        for (int n = 0; n < 8; n++) begin
            ra   = $urandom_range(1, 4);
            kk   = $urandom_range(1, 4);
            cb   = $urandom_range(1, 4);
            mode = $urandom_range(0, 3);
            rb   = (mode == 0) ? kk + $urandom_range(1, 2) : kk;
            la.delete();
            lb.delete();
            for (int r = 0; r < ra; r++) la.push_back(kk);
            for (int r = 0; r < rb; r++) lb.push_back(cb);
            if (mode == 1 && ra >= 2) la[$urandom_range(1, ra - 1)] = (kk == 1) ? 2 : kk - 1;
            if (mode == 2 && rb >= 2) lb[rb - 1] = cb % 4 + 1;
            run_case($sformatf("random%0d", n), la, lb, -1);
        end
    endtask

`ifdef MM_SEQ_OREADY_EN
    task automatic test_stall();
        int la[$]; int lb[$];
        int guard;
        logic [AW-1:0] ra0, rb0;
        la = '{2, 2};
        lb = '{2, 2};
        out_ready = 1'b0;
        drive_matrix("stall", la, 1'b0);
        drive_matrix("stall", lb, 1'b1);
        guard = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        ra0 = rd_addr_a;
        rb0 = rd_addr_b;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (out_valid !== 1'b1 || is_legal !== 1'b1 || change_row !== 1'b0 || mac_en !== 1'b0 ||
                rd_addr_a !== ra0 || rd_addr_b !== rb0) begin
                errors++;
                $display("FAIL stall hold[%0d]: got ov=%b lg=%b cr=%b mac_en=%b rd_a=%0d rd_b=%0d, expected ov=1 lg=1 cr=0 mac_en=0 rd_a=%0d rd_b=%0d",
                         s, out_valid, is_legal, change_row, mac_en, rd_addr_a, rd_addr_b, ra0, rb0);
            end
            @(posedge clk); #1;
            if (s == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall release: got ov=%b, expected 1", out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mac_en !== 1'b1 || mac_clr !== 1'b1 ||
            rd_addr_a !== AW'(0) || rd_addr_b !== AW'(1)) begin
            errors++;
            $display("FAIL stall advance: got ov=%b mac_en=%b mac_clr=%b rd_a=%0d rd_b=%0d, expected ov=0 mac_en=1 mac_clr=1 rd_a=0 rd_b=1",
                     out_valid, mac_en, mac_clr, rd_addr_a, rd_addr_b);
        end
        guard = 0;
        while (busy !== 1'b0 && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall drain: got busy=%b, expected 0", busy);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        col_end  = 1'b0;
        row_end  = 1'b0;
`ifdef MM_SEQ_OREADY_EN
        out_ready = 1'b1;
`endif
        test_reset();
        test_legal();
        test_ragged_a();
        test_mismatch();
        test_one_by_one();
        test_oversize();
        test_reset_mid();
        test_random();
`ifdef MM_SEQ_OREADY_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
